vga_rect_animator: RTL
======================

VGA_RECT_ANIMATOR -- requirements
Module: vga_rect_animator

Interface
- REQ-001 SHALL have parameter WIDTH_VISIBLE, default 150, meaning visible pixels per line.
- REQ-002 SHALL have parameter HEIGHT_VISIBLE, default 100, meaning visible lines per frame.
- REQ-003 SHALL have parameter PIXEL_BITWIDTH, default 11, meaning width of every coordinate/size bus.
- REQ-004 SHALL have parameter SPEED_BITWIDTH, default 4, meaning width of step sizes and frame divider.
- REQ-005 SHALL have port i_clk, input, 1, meaning the single clock; all logic on its rising edge.
- REQ-006 SHALL have port i_reset_n, input, 1, meaning the reset; it is asynchronous and active-low.
- REQ-007 SHALL have ports i_vga_x and i_vga_y, input, PIXEL_BITWIDTH each, meaning raster position from the VGA generator.
- REQ-008 SHALL have port i_enable, input, 1, meaning motion enabled.
- REQ-009 SHALL have port i_frame_div, input, SPEED_BITWIDTH, meaning move once every i_frame_div+1 frames.
- REQ-010 SHALL have config ports i_cfg_valid (1), i_cfg_x, i_cfg_y, i_cfg_width, i_cfg_height (PIXEL_BITWIDTH each), and i_cfg_dx, i_cfg_dy (SPEED_BITWIDTH each), all inputs.
- REQ-011 SHALL have port o_cfg_ready, output, 1, meaning config accepted this cycle when high with i_cfg_valid.
- REQ-012 SHALL have ports o_rect_x, o_rect_y, o_rect_width, o_rect_height, output, PIXEL_BITWIDTH each, meaning rectangle fed to the renderer.
- REQ-013 SHALL have port o_frame_tick, output, 1, meaning a one-cycle pulse when new rect values are committed.

Function
- REQ-014 SHALL detect vblank start as i_vga_x==0 && i_vga_y==HEIGHT_VISIBLE, true for exactly one cycle per frame.
- REQ-015 SHALL use FSM states WAIT, MOVE_X, MOVE_Y, COMMIT; WAIT->MOVE_X on vblank start; MOVE_X->MOVE_Y->COMMIT->WAIT unconditionally.
- REQ-016 SHALL register all outputs; rect outputs change only on the COMMIT->WAIT edge, so new values appear 4 cycles after the vblank-start cycle.
- REQ-017 SHALL pulse o_frame_tick high in the COMMIT cycle only.
- REQ-018 SHALL drive o_cfg_ready high in WAIT and low in MOVE_X, MOVE_Y and COMMIT.
- REQ-019 SHALL latch accepted config into a shadow register with a pending flag; a later accept before commit overwrites it.
- REQ-020 SHALL, at COMMIT with pending set, load rect from the shadow instead of motion, set directions to +x/+y, clear pending, and clear the frame counter.
- REQ-021 SHALL clamp committed config: width = min(cfg_width, WIDTH_VISIBLE) and x = min(cfg_x, WIDTH_VISIBLE-width); height and y likewise against HEIGHT_VISIBLE.
- REQ-022 SHALL count vblanks in a SPEED_BITWIDTH frame counter while i_enable is high; motion happens when counter==i_frame_div, then counter=0; counter holds 0 while i_enable is low.
- REQ-023 SHALL, in MOVE_X with motion due, compute x±dx at PIXEL_BITWIDTH+1 bits; if x+dx+width > WIDTH_VISIBLE, x=WIDTH_VISIBLE-width and the direction flips to -; if x<dx moving -, x=0 and the direction flips to +.
- REQ-024 SHALL apply identical rules for y in MOVE_Y against HEIGHT_VISIBLE.
- REQ-025 SHALL leave position and direction unchanged when the step is 0 or motion is not due.
- REQ-026 SHALL accept a config presented in the vblank-start cycle (state WAIT) and apply it at that same sequence's COMMIT.
- REQ-027 SHALL complete an in-progress MOVE/COMMIT sequence even if i_enable falls mid-sequence; the motion decision is made at MOVE_X entry.

Reset
- REQ-028 SHALL asynchronously, on i_reset_n low, set state=WAIT, o_rect_x=0, o_rect_y=0, o_rect_width=8, o_rect_height=8, dx=dy=1, directions +, counter=0, pending=0, o_frame_tick=0.
- REQ-029 SHALL drive o_cfg_ready=1 after reset, and any sequence in progress during reset SHALL be abandoned with no commit.

Structure
- REQ-030 SHALL place FSM state encodings, direction encoding and reset rect constants in the shared VGA package/header.
- REQ-031 SHALL use one sub-module, vga_axis_step (combinational position/size/step/dir -> next position/dir with clamping), shared by MOVE_X and MOVE_Y.

Verification
- REQ-032 SHALL check: reset, then first vblank with enable=1 and div=0 -> rect (1,1,8,8), o_frame_tick at vblank+3, outputs at vblank+4.
- REQ-033 SHALL check: cfg x=140, w=8, dx=3, then a moving frame -> x=142 with dir flipped; next frame x=139.
- REQ-034 SHALL check: cfg x=2, dx=3, moving left -> x=0 with dir +, then x=3.
- REQ-035 SHALL check: cfg w=200, x=50 -> committed w=150, x=0.
- REQ-036 SHALL check: div=2, enable=1 -> position changes only on every 3rd frame; enable=0 -> no change and o_frame_tick still pulses.
- REQ-037 SHALL check: i_cfg_valid held during MOVE_X -> no accept until WAIT; reset asserted in MOVE_Y -> outputs return to reset values with no tick.

Source files
------------

// File: rtl/vga_rect_animator_pkg.sv
// Shared encodings and reset constants for the VGA rectangle animator and its axis stepper.
package vga_rect_animator_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_MOVE_X = 2'd1,
    ST_MOVE_Y = 2'd2,
    ST_COMMIT = 2'd3
  } anim_state_t;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  localparam int RESET_RECT_X      = 0;
  localparam int RESET_RECT_Y      = 0;
  localparam int RESET_RECT_WIDTH  = 8;
  localparam int RESET_RECT_HEIGHT = 8;
  localparam int RESET_STEP        = 1;

endpackage

// File: rtl/vga_axis_step.sv
// One-axis motion step: advances a position by step in the current direction,
// clamping against 0 and limit-size and reversing direction on contact.
module vga_axis_step
  import vga_rect_animator_pkg::*;
#(
  parameter int PIXEL_BITWIDTH = 11,
  parameter int SPEED_BITWIDTH = 4
) (
  input  logic [PIXEL_BITWIDTH-1:0] pos,
  input  logic [PIXEL_BITWIDTH-1:0] size,
  input  logic [PIXEL_BITWIDTH-1:0] limit,
  input  logic [SPEED_BITWIDTH-1:0] step,
  input  dir_t                      dir,
  output logic [PIXEL_BITWIDTH-1:0] next_pos,
  output dir_t                      next_dir
);

  localparam int EXT_W = PIXEL_BITWIDTH + 1;

  logic [EXT_W-1:0] pos_ext;
  logic [EXT_W-1:0] size_ext;
  logic [EXT_W-1:0] limit_ext;
  logic [EXT_W-1:0] step_ext;
  logic [EXT_W-1:0] far_edge;

  always_comb begin
    pos_ext   = {1'b0, pos};
    size_ext  = {1'b0, size};
    limit_ext = {1'b0, limit};
    step_ext  = EXT_W'(step);
    // One extra bit so pos+step+size cannot wrap before the wall compare.
    far_edge  = pos_ext + step_ext + size_ext;
    next_pos  = pos;
    next_dir  = dir;
    if (step != '0) begin
      if (dir == DIR_POS) begin
        if (far_edge > limit_ext) begin
          next_pos = PIXEL_BITWIDTH'(limit_ext - size_ext);
          next_dir = DIR_NEG;
        end else begin
          next_pos = PIXEL_BITWIDTH'(pos_ext + step_ext);
        end
      end else if (pos_ext < step_ext) begin
        next_pos = '0;
        next_dir = DIR_POS;
      end else begin
        next_pos = PIXEL_BITWIDTH'(pos_ext - step_ext);
      end
    end
  end

endmodule

// File: rtl/vga_rect_animator.sv
// Bouncing-rectangle animator: once per vblank it steps X then Y, then commits
// the new rectangle (or a pending configuration) to the renderer outputs.
module vga_rect_animator
  import vga_rect_animator_pkg::*;
#(
  parameter int WIDTH_VISIBLE  = 150,
  parameter int HEIGHT_VISIBLE = 100,
  parameter int PIXEL_BITWIDTH = 11,
  parameter int SPEED_BITWIDTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [PIXEL_BITWIDTH-1:0] i_vga_x,
  input  logic [PIXEL_BITWIDTH-1:0] i_vga_y,
  input  logic                      i_enable,
  input  logic [SPEED_BITWIDTH-1:0] i_frame_div,
  input  logic                      i_cfg_valid,
  input  logic [PIXEL_BITWIDTH-1:0] i_cfg_x,
  input  logic [PIXEL_BITWIDTH-1:0] i_cfg_y,
  input  logic [PIXEL_BITWIDTH-1:0] i_cfg_width,
  input  logic [PIXEL_BITWIDTH-1:0] i_cfg_height,
  input  logic [SPEED_BITWIDTH-1:0] i_cfg_dx,
  input  logic [SPEED_BITWIDTH-1:0] i_cfg_dy,
  output logic                      o_cfg_ready,
  output logic [PIXEL_BITWIDTH-1:0] o_rect_x,
  output logic [PIXEL_BITWIDTH-1:0] o_rect_y,
  output logic [PIXEL_BITWIDTH-1:0] o_rect_width,
  output logic [PIXEL_BITWIDTH-1:0] o_rect_height,
  output logic                      o_frame_tick
);

  localparam logic [PIXEL_BITWIDTH-1:0] LIM_X = PIXEL_BITWIDTH'(WIDTH_VISIBLE);
  localparam logic [PIXEL_BITWIDTH-1:0] LIM_Y = PIXEL_BITWIDTH'(HEIGHT_VISIBLE);

  function automatic logic [PIXEL_BITWIDTH-1:0] sat_min(
    input logic [PIXEL_BITWIDTH-1:0] a,
    input logic [PIXEL_BITWIDTH-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

  anim_state_t               state;
  anim_state_t               state_nxt;
  logic                      vblank_start;
  logic                      frame_start;
  logic                      cfg_accept;
  logic                      move_due;
  logic                      pending;
  logic [SPEED_BITWIDTH-1:0] frame_cnt;
  logic [SPEED_BITWIDTH-1:0] step_x;
  logic [SPEED_BITWIDTH-1:0] step_y;
  logic [PIXEL_BITWIDTH-1:0] pos_x;
  logic [PIXEL_BITWIDTH-1:0] pos_y;
  dir_t                      dir_x;
  dir_t                      dir_y;

  logic [PIXEL_BITWIDTH-1:0] shd_x;
  logic [PIXEL_BITWIDTH-1:0] shd_y;
  logic [PIXEL_BITWIDTH-1:0] shd_w;
  logic [PIXEL_BITWIDTH-1:0] shd_h;
  logic [SPEED_BITWIDTH-1:0] shd_dx;
  logic [SPEED_BITWIDTH-1:0] shd_dy;

  logic [PIXEL_BITWIDTH-1:0] cfg_w_sat;
  logic [PIXEL_BITWIDTH-1:0] cfg_h_sat;
  logic [PIXEL_BITWIDTH-1:0] cfg_x_sat;
  logic [PIXEL_BITWIDTH-1:0] cfg_y_sat;

  logic [PIXEL_BITWIDTH-1:0] ax_pos;
  logic [PIXEL_BITWIDTH-1:0] ax_size;
  logic [PIXEL_BITWIDTH-1:0] ax_limit;
  logic [SPEED_BITWIDTH-1:0] ax_step;
  dir_t                      ax_dir;
  logic [PIXEL_BITWIDTH-1:0] ax_next_pos;
  dir_t                      ax_next_dir;

  assign vblank_start = (i_vga_x == '0) && (i_vga_y == LIM_Y);
  assign frame_start  = (state == ST_WAIT) && vblank_start;
  assign cfg_accept   = i_cfg_valid && o_cfg_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT:   if (vblank_start) state_nxt = ST_MOVE_X;
      ST_MOVE_X: state_nxt = ST_MOVE_Y;
      ST_MOVE_Y: state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_WAIT;
      default:   state_nxt = ST_WAIT;
    endcase
  end

  // Ready and tick are registered from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= ST_WAIT;
      o_cfg_ready  <= 1'b1;
      o_frame_tick <= 1'b0;
    end else begin
      state        <= state_nxt;
      o_cfg_ready  <= (state_nxt == ST_WAIT);
      o_frame_tick <= (state_nxt == ST_COMMIT);
    end
  end

  // Motion decision is frozen at MOVE_X entry so a mid-sequence enable drop cannot split a move.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      frame_cnt <= '0;
      move_due  <= 1'b0;
      pending   <= 1'b0;
    end else begin
      if (frame_start) move_due <= i_enable && (frame_cnt == i_frame_div);
      if ((state == ST_COMMIT) && pending) begin
        frame_cnt <= '0;
      end else if (!i_enable) begin
        frame_cnt <= '0;
      end else if (frame_start) begin
        frame_cnt <= (frame_cnt == i_frame_div) ? '0 : frame_cnt + SPEED_BITWIDTH'(1);
      end
      if (cfg_accept) begin
        pending <= 1'b1;
      end else if (state == ST_COMMIT) begin
        pending <= 1'b0;
      end
    end
  end

  // Shadow holds the most recent accepted configuration; validity lives in pending.
  always_ff @(posedge i_clk) begin
    if (cfg_accept) begin
      shd_x  <= i_cfg_x;
      shd_y  <= i_cfg_y;
      shd_w  <= i_cfg_width;
      shd_h  <= i_cfg_height;
      shd_dx <= i_cfg_dx;
      shd_dy <= i_cfg_dy;
    end
  end

  always_comb begin
    cfg_w_sat = sat_min(shd_w, LIM_X);
    cfg_h_sat = sat_min(shd_h, LIM_Y);
    cfg_x_sat = sat_min(shd_x, LIM_X - cfg_w_sat);
    cfg_y_sat = sat_min(shd_y, LIM_Y - cfg_h_sat);
  end

  always_comb begin
    ax_pos   = pos_x;
    ax_size  = o_rect_width;
    ax_limit = LIM_X;
    ax_step  = step_x;
    ax_dir   = dir_x;
    if (state == ST_MOVE_Y) begin
      ax_pos   = pos_y;
      ax_size  = o_rect_height;
      ax_limit = LIM_Y;
      ax_step  = step_y;
      ax_dir   = dir_y;
    end
  end

  vga_axis_step #(
    .PIXEL_BITWIDTH(PIXEL_BITWIDTH),
    .SPEED_BITWIDTH(SPEED_BITWIDTH)
  ) u_axis_step (
    .pos      (ax_pos),
    .size     (ax_size),
    .limit    (ax_limit),
    .step     (ax_step),
    .dir      (ax_dir),
    .next_pos (ax_next_pos),
    .next_dir (ax_next_dir)
  );

  // Working position moves in MOVE_X/MOVE_Y; renderer outputs only change leaving COMMIT.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pos_x         <= PIXEL_BITWIDTH'(RESET_RECT_X);
      pos_y         <= PIXEL_BITWIDTH'(RESET_RECT_Y);
      dir_x         <= DIR_POS;
      dir_y         <= DIR_POS;
      step_x        <= SPEED_BITWIDTH'(RESET_STEP);
      step_y        <= SPEED_BITWIDTH'(RESET_STEP);
      o_rect_x      <= PIXEL_BITWIDTH'(RESET_RECT_X);
      o_rect_y      <= PIXEL_BITWIDTH'(RESET_RECT_Y);
      o_rect_width  <= PIXEL_BITWIDTH'(RESET_RECT_WIDTH);
      o_rect_height <= PIXEL_BITWIDTH'(RESET_RECT_HEIGHT);
    end else begin
      case (state)
        ST_MOVE_X: begin
          if (move_due) begin
            pos_x <= ax_next_pos;
            dir_x <= ax_next_dir;
          end
        end
        ST_MOVE_Y: begin
          if (move_due) begin
            pos_y <= ax_next_pos;
            dir_y <= ax_next_dir;
          end
        end
        ST_COMMIT: begin
          if (pending) begin
            pos_x         <= cfg_x_sat;
            pos_y         <= cfg_y_sat;
            dir_x         <= DIR_POS;
            dir_y         <= DIR_POS;
            step_x        <= shd_dx;
            step_y        <= shd_dy;
            o_rect_x      <= cfg_x_sat;
            o_rect_y      <= cfg_y_sat;
            o_rect_width  <= cfg_w_sat;
            o_rect_height <= cfg_h_sat;
          end else begin
            o_rect_x <= pos_x;
            o_rect_y <= pos_y;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
